usb_tx_arbiter: RTL and testbench

USB_TX_ARBITER -- requirements
Module: usb_tx_arbiter

---
 rtl/usb_tx_arbiter.sv | 121 ++++++++++++
 tb/tb_usb_tx_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: merges a non-stallable ADC sample stream and a command-response
// byte stream onto one outbound byte FIFO. ADC words are sent MSB first.
// A waiting response packet gets the FIFO after at most MAXBURST back-to-back words.
module usb_tx_arbiter #(
  parameter int unsigned MAXBURST = 16
) (
  input  logic        RSTn,
  input  logic        clk50,
  input  logic        en,
  input  logic [31:0] adc_data,
  input  logic        adc_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_valid,
  input  logic        rsp_last,
  output logic        rsp_ready,
  input  logic        wrfull,
  output logic        wrreq,
  output logic [7:0]  fifo_data,
  input  logic        drop_clr,
  output logic [15:0] drop_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADC  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam logic [7:0] BURST_MAX = 8'(MAXBURST);

  state_t      state;
  state_t      state_nx;
  logic [31:0] hold;
  logic        hold_v;
  logic [1:0]  byte_idx;
  logic [7:0]  burst_cnt;

  logic        word_done;
  logic        capture;
  logic        drop;
  logic        rsp_take;

  // Hold register may be refilled in the same cycle its 4th byte is written.
  assign word_done = (state == ADC) && !wrfull && (byte_idx == 2'd3);
  assign capture   = adc_valid && en && (!hold_v || word_done);
  assign drop      = adc_valid && en && hold_v && !word_done;
  assign rsp_take  = (state == RSP) && rsp_valid && !wrfull;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx  = state;
    wrreq     = 1'b0;
    rsp_ready = 1'b0;
    fifo_data = '0;
    case (state)
      IDLE: begin
        if (hold_v && (!rsp_valid || (burst_cnt < BURST_MAX)))
          state_nx = ADC;
        else if (rsp_valid)
          state_nx = RSP;
      end
      ADC: begin
        wrreq = !wrfull;
        case (byte_idx)
          2'd0:    fifo_data = hold[31:24];
          2'd1:    fifo_data = hold[23:16];
          2'd2:    fifo_data = hold[15:8];
          default: fifo_data = hold[7:0];
        endcase
        if (word_done)
          state_nx = IDLE;
      end
      RSP: begin
        rsp_ready = !wrfull;
        wrreq     = rsp_valid && !wrfull;
        fifo_data = rsp_data;
        if (rsp_take && rsp_last)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      hold      <= '0;
      hold_v    <= 1'b0;
      byte_idx  <= '0;
      burst_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      state <= state_nx;

      if (capture) begin
        hold   <= adc_data;
        hold_v <= 1'b1;
      end else if (word_done) begin
        hold_v <= 1'b0;
      end

      // Index wraps back to 0 on the 4th byte, so every word starts at 0.
      if ((state == ADC) && !wrfull)
        byte_idx <= byte_idx + 2'd1;

      if (word_done) begin
        if (burst_cnt != BURST_MAX)
          burst_cnt <= burst_cnt + 8'd1;
      end else if (rsp_take && rsp_last) begin
        burst_cnt <= '0;
      end

      if (drop_clr)
        drop_cnt <= {15'd0, drop};
      else if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed bench for usb_tx_arbiter (MAXBURST=2).
module tb_usb_tx_arbiter;

  logic        clk50 = 1'b0;
  logic        RSTn;
  logic        en;
  logic [31:0] adc_data;
  logic        adc_valid;
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        rsp_last;
  logic        rsp_ready;
  logic        wrfull;
  logic        wrreq;
  logic [7:0]  fifo_data;
  logic        drop_clr;
  logic [15:0] drop_cnt;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk50 = ~clk50;

  usb_tx_arbiter #(.MAXBURST(2)) dut (
    .RSTn      (RSTn),
    .clk50     (clk50),
    .en        (en),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid),
    .rsp_last  (rsp_last),
    .rsp_ready (rsp_ready),
    .wrfull    (wrfull),
    .wrreq     (wrreq),
    .fifo_data (fifo_data),
    .drop_clr  (drop_clr),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int unsigned i);
    return w[31 - 8*i -: 8];
  endfunction

  // Called at a falling edge after inputs are set; checks outputs, moves to next falling edge.
  task automatic step(input string tag, input logic ew, input logic [7:0] ed,
                      input logic eb, input logic er);
    #1;
    n_cmp++;
    assert (wrreq === ew) else begin
      n_err++;
      $error("FAIL %s wrreq observed=%b expected=%b", tag, wrreq, ew);
    end
    if (ew) begin
      n_cmp++;
      assert (fifo_data === ed) else begin
        n_err++;
        $error("FAIL %s fifo_data observed=%h expected=%h", tag, fifo_data, ed);
      end
    end
    n_cmp++;
    assert (busy === eb) else begin
      n_err++;
      $error("FAIL %s busy observed=%b expected=%b", tag, busy, eb);
    end
    n_cmp++;
    assert (rsp_ready === er) else begin
      n_err++;
      $error("FAIL %s rsp_ready observed=%b expected=%b", tag, rsp_ready, er);
    end
    @(negedge clk50);
  endtask

  task automatic chk_drop(input string tag, input logic [15:0] exp);
    n_cmp++;
    assert (drop_cnt === exp) else begin
      n_err++;
      $error("FAIL %s drop_cnt observed=%0d expected=%0d", tag, drop_cnt, exp);
    end
  endtask

  initial begin
    logic [31:0] wa;
    logic [31:0] w0;
    logic [31:0] w5;
    logic [31:0] wc;
    logic [31:0] p [0:3];
    logic        ew;
    logic        eb;
    logic        er;
    logic [7:0]  ed;

    wa = 32'hA1B2C3D4;
    w0 = 32'h01020304;
    w5 = 32'h55667788;
    wc = 32'h0A0B0C0D;
    p[0] = 32'hA0A1A2A3;
    p[1] = 32'hB0B1B2B3;
    p[2] = 32'hC0C1C2C3;
    p[3] = 32'hD0D1D2D3;

    RSTn      = 1'b0;
    en        = 1'b1;
    adc_data  = '0;
    adc_valid = 1'b0;
    rsp_data  = 8'h5A;
    rsp_valid = 1'b1;
    rsp_last  = 1'b1;
    wrfull    = 1'b0;
    drop_clr  = 1'b0;

    // Reset state, with a response offered that must not be accepted
    @(negedge clk50);
    step("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    assert (fifo_data === 8'h00) else begin
      n_err++;
      $error("FAIL reset fifo_data observed=%h expected=00", fifo_data);
    end
    chk_drop("reset", 16'd0);
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    step("reset2", 1'b0, 8'h00, 1'b0, 1'b0);
    RSTn = 1'b1;

    // Single word, no backpressure
    for (int k = 0; k <= 6; k++) begin
      adc_valid = (k == 0);
      adc_data  = wa;
      ew = (k >= 2 && k <= 5);
      ed = ew ? byte_of(wa, k - 2) : 8'h00;
      step($sformatf("single_c%0d", k), ew, ed, ew, 1'b0);
    end
    chk_drop("single", 16'd0);

    // Samples ignored while disabled
    en = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      adc_valid = (k <= 1);
      adc_data  = 32'hEEEEEEEE;
      step($sformatf("en_off_c%0d", k), 1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk_drop("en_off", 16'd0);
    en = 1'b1;

    // FIFO full during byte 2 for three cycles
    for (int k = 0; k <= 9; k++) begin
      adc_valid = (k == 0);
      adc_data  = wa;
      wrfull    = (k >= 3 && k <= 5);
      ew = (k == 2) || (k >= 6 && k <= 8);
      ed = (k == 2) ? 8'hA1 : (k == 6) ? 8'hB2 : (k == 7) ? 8'hC3 : (k == 8) ? 8'hD4 : 8'h00;
      eb = (k >= 2 && k <= 8);
      step($sformatf("stall_c%0d", k), ew, ed, eb, 1'b0);
    end
    wrfull = 1'b0;

    // Sample every cycle for 10 cycles: words from cycles 0 and 5 go out, 8 dropped
    for (int k = 0; k <= 11; k++) begin
      adc_valid = (k < 10);
      adc_data  = (k == 0) ? w0 : (k == 5) ? w5 : (32'hBAD00000 | 32'(k));
      if (k == 5)  chk_drop("flood_c5", 16'd4);
      if (k == 10) chk_drop("flood_c10", 16'd8);
      if (k >= 2 && k <= 5) begin
        ew = 1'b1; ed = byte_of(w0, k - 2);
      end else if (k >= 7 && k <= 10) begin
        ew = 1'b1; ed = byte_of(w5, k - 7);
      end else begin
        ew = 1'b0; ed = 8'h00;
      end
      step($sformatf("flood_c%0d", k), ew, ed, ew, 1'b0);
    end
    chk_drop("flood_end", 16'd8);

    // Plain clear, then clear coinciding with a drop
    drop_clr = 1'b1;
    step("clr", 1'b0, 8'h00, 1'b0, 1'b0);
    drop_clr = 1'b0;
    chk_drop("clr", 16'd0);
    for (int k = 0; k <= 6; k++) begin
      adc_valid = (k <= 1);
      adc_data  = (k == 0) ? wc : 32'hBAD0BAD0;
      drop_clr  = (k == 1);
      if (k == 2) chk_drop("clr_drop", 16'd1);
      ew = (k >= 2 && k <= 5);
      ed = ew ? byte_of(wc, k - 2) : 8'h00;
      step($sformatf("clr_drop_c%0d", k), ew, ed, ew, 1'b0);
    end
    drop_clr = 1'b0;

    // Reset after byte 2 of a word
    for (int k = 0; k <= 3; k++) begin
      adc_valid = (k == 0);
      adc_data  = wa;
      ew = (k >= 2);
      ed = (k == 2) ? 8'hA1 : 8'hB2;
      step($sformatf("rst_mid_c%0d", k), ew, ed, ew, 1'b0);
    end
    RSTn = 1'b0;
    step("rst_mid_low", 1'b0, 8'h00, 1'b0, 1'b0);
    chk_drop("rst_mid_low", 16'd0);
    RSTn = 1'b1;
    for (int k = 0; k <= 3; k++)
      step($sformatf("rst_mid_after_c%0d", k), 1'b0, 8'h00, 1'b0, 1'b0);
    chk_drop("rst_mid_after", 16'd0);

    // Burst limit of 2 with a waiting 3-byte response packet
    for (int k = 0; k <= 20; k++) begin
      adc_valid = (k % 5 == 0) && (k <= 15);
      adc_data  = p[k / 5 > 3 ? 3 : k / 5];
      rsp_valid = (k >= 1 && k <= 14);
      rsp_data  = (k <= 12) ? 8'h10 : (k == 13) ? 8'h11 : 8'h12;
      rsp_last  = (k == 14);
      if (k == 15) chk_drop("burst_c15", 16'd0);
      if (k == 16) chk_drop("burst_c16", 16'd1);
      er = 1'b0;
      if (k >= 2 && k <= 5) begin
        ew = 1'b1; ed = byte_of(p[0], k - 2);
      end else if (k >= 7 && k <= 10) begin
        ew = 1'b1; ed = byte_of(p[1], k - 7);
      end else if (k >= 12 && k <= 14) begin
        ew = 1'b1; er = 1'b1; ed = 8'h10 + 8'(k - 12);
      end else if (k >= 16 && k <= 19) begin
        ew = 1'b1; ed = byte_of(p[2], k - 16);
      end else begin
        ew = 1'b0; ed = 8'h00;
      end
      step($sformatf("burst_c%0d", k), ew, ed, ew, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
